// File: rtl/bc_array_sequencer_pkg.sv
// ============================================================================
//  Module   : bc_array_sequencer_pkg
//  Brief    : Shared encodings for the array sequencer: array op codes,
//             gauss_op codes, host command codes and sequencer states.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bc_array_sequencer_pkg;

    // Array op_in encodings
    localparam logic [3:0] OP_IDLE     = 4'b0000;
    localparam logic [3:0] OP_GAUSS    = 4'b0001;
    localparam logic [3:0] OP_LOAD_KEY = 4'b0011;
    localparam logic [3:0] OP_EVAL     = 4'b0100;
    localparam logic [3:0] OP_SHIFT    = 4'b0101;
    localparam logic [3:0] OP_MUL_RAND = 4'b0110;

    // Array gauss_op_in encodings
    localparam logic [1:0] GOP_PASS = 2'b00;
    localparam logic [1:0] GOP_NORM = 2'b01;
    localparam logic [1:0] GOP_ADD  = 2'b10;
    localparam logic [1:0] GOP_KEEP = 2'b11;

    // Host command codes (5..7 are illegal)
    typedef enum logic [2:0] {
        CMD_LOAD_KEY = 3'd0,
        CMD_SHIFT    = 3'd1,
        CMD_MUL_RAND = 3'd2,
        CMD_EVAL     = 3'd3,
        CMD_GAUSS    = 3'd4
    } cmd_code_e;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_G_START = 3'd2,
        S_G_ELIM  = 3'd3,
        S_DONE    = 3'd4
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/bc_seq_counter.sv
// ============================================================================
//  Module   : bc_seq_counter
//  Brief    : Loadable down-counter with a zero flag. Load has priority over
//             decrement; decrement saturates at zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/bc_array_sequencer.sv
// ============================================================================
//  Module   : bc_array_sequencer
//  Brief    : Accepts one command at a time and drives the array's start/op/
//             gauss_op controls for the command's duration, then pulses done.
//             Macro BC_SEQ_GAUSS_EN enables the GAUSS (pivot loop) command;
//             without it code 4 is treated as illegal.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bc_array_sequencer
    import bc_array_sequencer_pkg::*;
#(
    parameter int OP_CODE_LEN = 4,
    parameter int LEN_W       = 8,
    parameter int N_PIVOT     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_code,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   pivot_zero,
    output logic                   start_out,
    output logic [OP_CODE_LEN-1:0] op_out,
    output logic [1:0]             gauss_op_out,
    output logic                   done,
    output logic                   err
);

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_RUN     = S_RUN;
    localparam logic [2:0] ST_DONE    = S_DONE;
`ifdef BC_SEQ_GAUSS_EN
    localparam logic [2:0] ST_G_START = S_G_START;
    localparam logic [2:0] ST_G_ELIM  = S_G_ELIM;
    localparam int         PIV_W      = (N_PIVOT > 1) ? $clog2(N_PIVOT) : 1;
`endif

    logic [2:0]             state_q, state_d;
    logic [2:0]             code_q, code_d;
    logic                   ready_q, ready_d;
    logic                   start_q, start_d;
    logic [OP_CODE_LEN-1:0] op_q, op_d;
    logic [1:0]             gop_q, gop_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   w_accept;
    logic [LEN_W-1:0]       w_len_m1;
    logic [2:0]             w_code;
    logic                   w_is_run;
    logic                   w_is_gauss;
    logic                   w_beat_load;
    logic [LEN_W-1:0]       w_beat_val;
    logic                   w_beat_dec;
    logic                   w_beat_zero;

    assign w_accept = cmd_valid & ready_q;
    // Beat counter runs L-1..0, so a zero length behaves as one beat
    assign w_len_m1 = (cmd_len == '0) ? '0 : cmd_len - LEN_W'(1);
    assign w_code   = w_accept ? cmd_code : code_q;
    assign w_is_run = (cmd_code <= CMD_EVAL);

`ifdef BC_SEQ_GAUSS_EN
    logic [LEN_W-1:0] len_q;
    logic             w_piv_zero;

    assign w_is_gauss  = (cmd_code == CMD_GAUSS);
    // RUN loads its length at acceptance; every G_START reloads for its G_ELIM
    assign w_beat_load = w_accept | (state_q == ST_G_START);
    assign w_beat_val  = w_accept ? w_len_m1 : len_q;
    assign w_beat_dec  = (state_q == ST_RUN) | (state_q == ST_G_ELIM);

    // Latched beat length, reused for every pivot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (w_accept) begin
            len_q <= w_len_m1;
        end
    end

    bc_seq_counter #(.W(PIV_W)) u_pivot_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_accept),
        .load_val_i (PIV_W'(N_PIVOT - 1)),
        .dec_i      ((state_q == ST_G_ELIM) & w_beat_zero),
        .zero_o     (w_piv_zero)
    );
`else
    logic w_unused_pivot;

    assign w_unused_pivot = pivot_zero;
    assign w_is_gauss     = 1'b0;
    assign w_beat_load    = w_accept;
    assign w_beat_val     = w_len_m1;
    assign w_beat_dec     = (state_q == ST_RUN);
`endif

    bc_seq_counter #(.W(LEN_W)) u_beat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_beat_load),
        .load_val_i (w_beat_val),
        .dec_i      (w_beat_dec),
        .zero_o     (w_beat_zero)
    );

    // Next-state logic; err is cleared on acceptance and set on entry to DONE by error
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        code_d  = w_accept ? cmd_code : code_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    err_d = 1'b0;
                    if (w_is_run) begin
                        state_d = ST_RUN;
                    end else if (w_is_gauss) begin
`ifdef BC_SEQ_GAUSS_EN
                        state_d = ST_G_START;
`endif
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_beat_zero) begin
                    state_d = ST_DONE;
                end
            end
`ifdef BC_SEQ_GAUSS_EN
            ST_G_START: begin
                if (pivot_zero) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_G_ELIM;
                end
            end
            ST_G_ELIM: begin
                if (w_beat_zero) begin
                    state_d = w_piv_zero ? ST_DONE : ST_G_START;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a plain register
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        start_d = 1'b0;
        op_d    = OP_CODE_LEN'(OP_IDLE);
        gop_d   = GOP_PASS;
        case (state_d)
            ST_RUN: begin
                case (w_code)
                    CMD_LOAD_KEY: op_d = OP_CODE_LEN'(OP_LOAD_KEY);
                    CMD_SHIFT:    op_d = OP_CODE_LEN'(OP_SHIFT);
                    CMD_MUL_RAND: op_d = OP_CODE_LEN'(OP_MUL_RAND);
                    CMD_EVAL: begin
                        op_d  = OP_CODE_LEN'(OP_EVAL);
                        gop_d = GOP_KEEP;
                    end
                    default: op_d = OP_CODE_LEN'(OP_IDLE);
                endcase
            end
`ifdef BC_SEQ_GAUSS_EN
            ST_G_START: begin
                start_d = 1'b1;
                op_d    = OP_CODE_LEN'(OP_GAUSS);
                gop_d   = GOP_KEEP;
            end
            ST_G_ELIM: begin
                op_d  = OP_CODE_LEN'(OP_GAUSS);
                gop_d = GOP_ADD;
            end
`endif
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            op_q    <= '0;
            gop_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ready_q <= ready_d;
            start_q <= start_d;
            op_q    <= op_d;
            gop_q   <= gop_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign start_out    = start_q;
    assign op_out       = op_q;
    assign gauss_op_out = gop_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bc_array_sequencer.sv
// ============================================================================
//  Module   : tb_bc_array_sequencer
//  Brief    : Table-driven bench for bc_array_sequencer with a per-cycle
//             expected-output queue, plus reset corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bc_array_sequencer;

    localparam int N_PIV = 4;
`ifdef BC_SEQ_GAUSS_EN
    localparam bit GAUSS_EN = 1'b1;
`else
    localparam bit GAUSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_code = 3'd0;
    logic [7:0] cmd_len = 8'd0;
    logic       pivot_zero = 1'b0;
    logic       cmd_ready;
    logic       start_out;
    logic [3:0] op_out;
    logic [1:0] gauss_op_out;
    logic       done;
    logic       err;

    bc_array_sequencer #(
        .OP_CODE_LEN (4),
        .LEN_W       (8),
        .N_PIVOT     (N_PIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_code     (cmd_code),
        .cmd_len      (cmd_len),
        .pivot_zero   (pivot_zero),
        .start_out    (start_out),
        .op_out       (op_out),
        .gauss_op_out (gauss_op_out),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy;
        logic       st;
        logic [3:0] op;
        logic [1:0] gop;
        logic       dn;
        logic       er;
    } exp_t;

    typedef struct {
        logic [2:0] code;
        logic [7:0] len;
        int         pz_at;
        logic [3:0] op;
        logic [1:0] gop;
        bit         illegal;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(bit r, bit s, logic [3:0] o, logic [1:0] g, bit d, bit e);
        exp_t x;
        x.rdy = r; x.st = s; x.op = o; x.gop = g; x.dn = d; x.er = e;
        return x;
    endfunction

    function automatic vec_t mkv(logic [2:0] c, logic [7:0] l, int pz,
                                 logic [3:0] o, logic [1:0] g, bit ill);
        vec_t v;
        v.code = c; v.len = l; v.pz_at = pz; v.op = o; v.gop = g; v.illegal = ill;
        return v;
    endfunction

    task automatic check_rec(input string tag, input exp_t e);
        exp_t a;
        a = {cmd_ready, start_out, op_out, gauss_op_out, done, err};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got rdy=%b start=%b op=%b gop=%b done=%b err=%b, expected rdy=%b start=%b op=%b gop=%b done=%b err=%b",
                     tag, a.rdy, a.st, a.op, a.gop, a.dn, a.er,
                     e.rdy, e.st, e.op, e.gop, e.dn, e.er);
        end
    endtask

    // Wait (bounded) at a negedge for cmd_ready; returns ok=0 on timeout
    task automatic wait_ready(input string tag, output bit ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = (cmd_ready === 1'b1);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout: got cmd_ready=%b, expected 1", tag, cmd_ready);
        end
    endtask

    // Build the expected cycle-by-cycle output stream, issue the command, drain
    task automatic run_vec(input string tag, input vec_t v);
        int  L;
        int  pidx;
        bit  aborted;
        bit  ok;
        bit  fin_err;
        exp_t e;
        L = (v.len == 8'd0) ? 1 : int'(v.len);
        sb_q.delete();
        aborted = 1'b0;
        fin_err = 1'b0;
        if (v.illegal) begin
            sb_q.push_back(mk(0, 0, 4'b0000, 2'b00, 1, 1));
            fin_err = 1'b1;
        end else if (v.code == 3'd4) begin
            for (int p = 0; p < N_PIV && !aborted; p++) begin
                sb_q.push_back(mk(0, 1, 4'b0001, 2'b11, 0, 0));
                if (p == v.pz_at) begin
                    sb_q.push_back(mk(0, 0, 4'b0000, 2'b00, 1, 1));
                    aborted = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    for (int b = 0; b < L; b++) sb_q.push_back(mk(0, 0, 4'b0001, 2'b10, 0, 0));
                end
            end
            if (!aborted) sb_q.push_back(mk(0, 0, 4'b0000, 2'b00, 1, 0));
        end else begin
            for (int b = 0; b < L; b++) sb_q.push_back(mk(0, 0, v.op, v.gop, 0, 0));
            sb_q.push_back(mk(0, 0, 4'b0000, 2'b00, 1, 0));
        end
        sb_q.push_back(mk(1, 0, 4'b0000, 2'b00, 0, fin_err));

        wait_ready(tag, ok);
        if (!ok) return;
        cmd_valid = 1'b1;
        cmd_code  = v.code;
        cmd_len   = v.len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_code  = 3'($urandom);
        cmd_len   = 8'($urandom);
        pidx = 0;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            if (e.st) begin
                pivot_zero = (pidx == v.pz_at);
                pidx++;
            end else begin
                pivot_zero = 1'($urandom);
            end
            check_rec(tag, e);
        end
        pivot_zero = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        vecs[0]  = mkv(3'd3, 8'd3,   -1, 4'b0100, 2'b11, 1'b0);  // EVAL L=3
        vecs[1]  = mkv(3'd1, 8'd0,   -1, 4'b0101, 2'b00, 1'b0);  // SHIFT len 0 -> 1 beat
        vecs[2]  = mkv(3'd0, 8'd1,   -1, 4'b0011, 2'b00, 1'b0);  // LOAD_KEY L=1
        vecs[3]  = mkv(3'd2, 8'd4,   -1, 4'b0110, 2'b00, 1'b0);  // MUL_RAND L=4
        vecs[4]  = mkv(3'd6, 8'd5,   -1, 4'b0000, 2'b00, 1'b1);  // illegal
        vecs[5]  = mkv(3'd5, 8'd2,   -1, 4'b0000, 2'b00, 1'b1);  // illegal
        vecs[6]  = mkv(3'd7, 8'd0,   -1, 4'b0000, 2'b00, 1'b1);  // illegal
        vecs[7]  = mkv(3'd4, 8'd2,   -1, 4'b0001, 2'b10, !GAUSS_EN);  // GAUSS full
        vecs[8]  = mkv(3'd4, 8'd2,    2, 4'b0001, 2'b10, !GAUSS_EN);  // zero pivot at 3rd
        vecs[9]  = mkv(3'd4, 8'd0,    0, 4'b0001, 2'b10, !GAUSS_EN);  // zero pivot at 1st
        vecs[10] = mkv(3'd0, 8'd255, -1, 4'b0011, 2'b00, 1'b0);  // max length
        vecs[11] = mkv(3'd3, 8'd2,   -1, 4'b0100, 2'b11, 1'b0);  // EVAL after error

        // Reset state: everything low, including cmd_ready, while asserted
        repeat (2) @(negedge clk);
        check_rec("reset_hold", mk(0, 0, 4'b0000, 2'b00, 0, 0));
        rst_n = 1'b1;
        @(negedge clk);
        check_rec("ready_after_release", mk(1, 0, 4'b0000, 2'b00, 0, 0));

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during MUL_RAND beat 5 of 10: immediate clear, no done
        wait_ready("midreset", ok);
        if (ok) begin
            cmd_valid = 1'b1;
            cmd_code  = 3'd2;
            cmd_len   = 8'd10;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            for (int b = 1; b <= 5; b++) begin
                @(negedge clk);
                check_rec($sformatf("midreset_beat%0d", b), mk(0, 0, 4'b0110, 2'b00, 0, 0));
            end
            #1;
            rst_n = 1'b0;
            #1;
            check_rec("midreset_async_clear", mk(0, 0, 4'b0000, 2'b00, 0, 0));
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check_rec("midreset_no_done", mk(0, 0, 4'b0000, 2'b00, 0, 0));
            end
            rst_n = 1'b1;
            @(negedge clk);
            check_rec("midreset_ready_after_release", mk(1, 0, 4'b0000, 2'b00, 0, 0));
        end
        run_vec("post_reset_eval", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
